data_memory_bytelane: RTL and testbench

- Parametrised successor to the MEM-stage data RAM of the MIPS pipeline.
- Byte-addressed, with byte/halfword/word stores and loads; loads are sign- or zero-extended (LB/LBU/LH/LHU/LW, SB/SH/SW).
- Flags misaligned accesses.
- Adds an independent word-wide debug read port for the debug unit, plus a sequential clear engine that zeroes the whole array between program loads.

---
 rtl/data_memory_bytelane.sv | 163 ++++++++++++++++
 tb/tb_data_memory_bytelane.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bytelane.sv
// Byte-addressed data RAM with sign/zero-extending loads, debug read port and sequential clear engine.
// Loads/debug reads: 1-cycle latency; no backpressure, CPU port is inert (stores dropped, loads 0) while o_busy.
module data_memory_bytelane #(
  parameter int NB_DATA      = 32,
  parameter int MEMORY_DEPTH = 64,
  parameter int NB_ADDR      = 8,
  parameter int NB_WADDR     = 6
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_mem_write,
  input  logic                i_mem_read,
  input  logic [NB_ADDR-1:0]  i_address,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [NB_DATA-1:0]  i_write_data,
  output logic [NB_DATA-1:0]  o_read_data,
  output logic                o_misaligned,
  input  logic                i_debug_read,
  input  logic [NB_WADDR-1:0] i_debug_address,
  output logic [NB_DATA-1:0]  o_debug_data,
  input  logic                i_clear,
  output logic                o_busy
);

  localparam int                NB_LANES = NB_DATA / 8;
  localparam logic [NB_WADDR-1:0] LAST_WORD = NB_WADDR'(MEMORY_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [NB_DATA-1:0] mem_q [MEMORY_DEPTH] = '{default: '0};

  state_t              state_q, state_d;
  logic [NB_WADDR-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [NB_DATA-1:0]  rd_q, rd_d;
  logic                mis_q, mis_d;
  logic [NB_DATA-1:0]  dbg_q, dbg_d;

  logic [NB_WADDR-1:0] word;
  logic [1:0]          off;
  logic                sweeping;
  logic                mis;
  logic [NB_DATA-1:0]  rword;
  logic [7:0]          rbyte;
  logic [15:0]         rhalf;
  logic [NB_DATA-1:0]  ld_val;
  logic                we;
  logic [NB_WADDR-1:0] waddr;
  logic [NB_LANES-1:0] wbe;
  logic [NB_DATA-1:0]  wdat;

  assign word     = i_address[NB_ADDR-1:2];
  assign off      = i_address[1:0];
  assign sweeping = (state_q == CLEAR);

  always_comb begin
    mis = 1'b0;
    if (i_enable && (i_mem_read || i_mem_write)) begin
      mis = (i_size == 2'b01 && off[0]) || (i_size == 2'b10 && off != 2'b00) || (i_size == 2'b11);
    end

    rword = mem_q[word];
    rbyte = rword[{off, 3'b000} +: 8];
    rhalf = off[1] ? rword[31:16] : rword[15:0];
    case (i_size)
      2'b00:   ld_val = i_unsigned ? {{(NB_DATA-8){1'b0}}, rbyte}
                                   : {{(NB_DATA-8){rbyte[7]}}, rbyte};
      2'b01:   ld_val = i_unsigned ? {{(NB_DATA-16){1'b0}}, rhalf}
                                   : {{(NB_DATA-16){rhalf[15]}}, rhalf};
      default: ld_val = rword;
    endcase

    // The sweep owns the write port; CPU stores only land while idle.
    we    = 1'b0;
    waddr = word;
    wbe   = '1;
    wdat  = i_write_data;
    if (sweeping) begin
      we    = 1'b1;
      waddr = cnt_q;
      wdat  = '0;
    end else if (i_enable && i_mem_write && !mis) begin
      we = 1'b1;
      case (i_size)
        2'b00: begin
          wbe  = NB_LANES'(1) << off;
          wdat = {NB_LANES{i_write_data[7:0]}};
        end
        2'b01: begin
          wbe  = NB_LANES'(3) << off;
          wdat = {(NB_LANES/2){i_write_data[15:0]}};
        end
        default: ;
      endcase
    end

    rd_d  = rd_q;
    mis_d = mis_q;
    if (i_enable) begin
      mis_d = mis && !sweeping;
      rd_d  = (i_mem_read && !mis && !sweeping) ? ld_val : '0;
    end

    dbg_d = i_debug_read ? mem_q[i_debug_address] : dbg_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (i_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      dbg_q   <= dbg_d;
    end
  end

  // Array is deliberately outside reset so an interrupted sweep leaves untouched words intact.
  always_ff @(posedge i_clock) begin
    if (we) begin
      for (int i = 0; i < NB_LANES; i++) begin
        if (wbe[i]) mem_q[waddr][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign o_read_data  = rd_q;
  assign o_misaligned = mis_q;
  assign o_debug_data = dbg_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench for data_memory_bytelane: loads/stores, faults, debug port, clear sweep and reset mid-sweep.
module tb_data_memory_bytelane;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_mem_write = 1'b0;
  logic        i_mem_read = 1'b0;
  logic [7:0]  i_address = '0;
  logic [1:0]  i_size = '0;
  logic        i_unsigned = 1'b0;
  logic [31:0] i_write_data = '0;
  logic [31:0] o_read_data;
  logic        o_misaligned;
  logic        i_debug_read = 1'b0;
  logic [5:0]  i_debug_address = '0;
  logic [31:0] o_debug_data;
  logic        i_clear = 1'b0;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  data_memory_bytelane dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_mem_write(i_mem_write), .i_mem_read(i_mem_read), .i_address(i_address),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_write_data(i_write_data),
    .o_read_data(o_read_data), .o_misaligned(o_misaligned),
    .i_debug_read(i_debug_read), .i_debug_address(i_debug_address),
    .o_debug_data(o_debug_data), .i_clear(i_clear), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic cpu(input logic wr, input logic rd, input logic [7:0] a,
                     input logic [1:0] sz, input logic un, input logic [31:0] wd);
    i_enable = 1'b1; i_mem_write = wr; i_mem_read = rd;
    i_address = a; i_size = sz; i_unsigned = un; i_write_data = wd;
    step();
    i_enable = 1'b0; i_mem_write = 1'b0; i_mem_read = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    step(); step();
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", o_read_data); end
    total++; if (o_debug_data !== 32'h0) begin bad++; $display("FAIL reset_dbg got=%h exp=0", o_debug_data); end
    total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", o_misaligned); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    i_reset_n = 1'b1;
    step();
  endtask

  task automatic test_word();
    cpu(1, 0, 8'h10, 2'b10, 0, 32'hDEADBEEF);
    total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL sw_mis got=%b exp=0", o_misaligned); end
    cpu(0, 1, 8'h10, 2'b10, 0, 32'h0);
    total++; if (o_read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw got=%h exp=deadbeef", o_read_data); end
    total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL lw_mis got=%b exp=0", o_misaligned); end
  endtask

  task automatic test_byte();
    cpu(1, 0, 8'h10, 2'b10, 0, 32'h0);
    cpu(1, 0, 8'h13, 2'b00, 0, 32'h12345680);
    cpu(0, 1, 8'h13, 2'b00, 0, 32'h0);
    total++; if (o_read_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=ffffff80", o_read_data); end
    cpu(0, 1, 8'h13, 2'b00, 1, 32'h0);
    total++; if (o_read_data !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", o_read_data); end
    cpu(0, 1, 8'h10, 2'b10, 1, 32'h0);
    total++; if (o_read_data !== 32'h80000000) begin bad++; $display("FAIL lw_after_sb got=%h exp=80000000", o_read_data); end
  endtask

  task automatic test_half();
    cpu(1, 0, 8'h20, 2'b10, 0, 32'h0);
    cpu(1, 0, 8'h22, 2'b01, 0, 32'hABCD8001);
    cpu(0, 1, 8'h22, 2'b01, 0, 32'h0);
    total++; if (o_read_data !== 32'hFFFF8001) begin bad++; $display("FAIL lh got=%h exp=ffff8001", o_read_data); end
    cpu(0, 1, 8'h22, 2'b01, 1, 32'h0);
    total++; if (o_read_data !== 32'h00008001) begin bad++; $display("FAIL lhu got=%h exp=00008001", o_read_data); end
    cpu(1, 0, 8'h21, 2'b01, 0, 32'h0000BEEF);
    total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL sh_odd_mis got=%b exp=1", o_misaligned); end
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL sh_odd_rd got=%h exp=0", o_read_data); end
    cpu(0, 1, 8'h20, 2'b10, 0, 32'h0);
    total++; if (o_read_data !== 32'h80010000) begin bad++; $display("FAIL lw_after_bad_sh got=%h exp=80010000", o_read_data); end
    total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", o_misaligned); end
    cpu(1, 0, 8'h20, 2'b01, 0, 32'h00007FFF);
    cpu(0, 1, 8'h20, 2'b01, 0, 32'h0);
    total++; if (o_read_data !== 32'h00007FFF) begin bad++; $display("FAIL lh_pos got=%h exp=00007fff", o_read_data); end
    cpu(0, 1, 8'h20, 2'b10, 0, 32'h0);
    total++; if (o_read_data !== 32'h80017FFF) begin bad++; $display("FAIL lw_halves got=%h exp=80017fff", o_read_data); end
  endtask

  task automatic test_misaligned();
    cpu(0, 1, 8'h10, 2'b10, 0, 32'h0);
    cpu(0, 1, 8'h0E, 2'b10, 0, 32'h0);
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL lw_0e_rd got=%h exp=0", o_read_data); end
    total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL lw_0e_mis got=%b exp=1", o_misaligned); end
    step();
    total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL mis_hold_disabled got=%b exp=1", o_misaligned); end
    cpu(0, 1, 8'h10, 2'b10, 0, 32'h0);
    total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL mis_cleared got=%b exp=0", o_misaligned); end
    total++; if (o_read_data !== 32'h80000000) begin bad++; $display("FAIL lw_10 got=%h exp=80000000", o_read_data); end
    step();
    total++; if (o_read_data !== 32'h80000000) begin bad++; $display("FAIL rd_hold_disabled got=%h exp=80000000", o_read_data); end
    cpu(0, 1, 8'h10, 2'b11, 0, 32'h0);
    total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL size11_ld_mis got=%b exp=1", o_misaligned); end
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL size11_ld_rd got=%h exp=0", o_read_data); end
    cpu(1, 0, 8'h10, 2'b11, 0, 32'hFFFFFFFF);
    total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL size11_st_mis got=%b exp=1", o_misaligned); end
    cpu(0, 1, 8'h10, 2'b10, 0, 32'h0);
    total++; if (o_read_data !== 32'h80000000) begin bad++; $display("FAIL size11_st_nowrite got=%h exp=80000000", o_read_data); end
    cpu(0, 0, 8'h10, 2'b10, 0, 32'h0);
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL en_noread got=%h exp=0", o_read_data); end
  endtask

  task automatic test_read_first();
    cpu(1, 0, 8'h30, 2'b10, 0, 32'h11111111);
    i_debug_read = 1'b1; i_debug_address = 6'd12;
    cpu(1, 1, 8'h30, 2'b10, 0, 32'h22222222);
    i_debug_read = 1'b0; i_debug_address = 6'd4;
    total++; if (o_read_data !== 32'h11111111) begin bad++; $display("FAIL rdw_cpu got=%h exp=11111111", o_read_data); end
    total++; if (o_debug_data !== 32'h11111111) begin bad++; $display("FAIL rdw_dbg got=%h exp=11111111", o_debug_data); end
    cpu(0, 1, 8'h30, 2'b10, 0, 32'h0);
    total++; if (o_read_data !== 32'h22222222) begin bad++; $display("FAIL rdw_new got=%h exp=22222222", o_read_data); end
    total++; if (o_debug_data !== 32'h11111111) begin bad++; $display("FAIL dbg_hold got=%h exp=11111111", o_debug_data); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 64; i++) cpu(1, 0, 8'(i * 4), 2'b10, 0, 32'hA5000000 | i);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    n = 0;
    while (o_busy === 1'b1 && n < 200) begin
      n++;
      i_enable = 1'b0; i_mem_write = 1'b0; i_mem_read = 1'b0; i_clear = 1'b0;
      if (n == 20) begin
        i_enable = 1'b1; i_mem_write = 1'b1; i_address = 8'h00; i_size = 2'b10; i_write_data = 32'h12345678;
      end else if (n == 21) begin
        i_enable = 1'b1; i_mem_read = 1'b1; i_address = 8'hFC; i_size = 2'b10;
      end else if (n == 22) begin
        i_clear = 1'b1;
      end
      step();
      if (n == 21) begin
        total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL busy_load got=%h exp=0", o_read_data); end
      end
    end
    i_enable = 1'b0; i_mem_write = 1'b0; i_mem_read = 1'b0; i_clear = 1'b0;
    total++; if (n !== 64) begin bad++; $display("FAIL busy_cycles got=%0d exp=64", n); end
    for (int i = 0; i < 64; i++) begin
      i_debug_read = 1'b1; i_debug_address = 6'(i);
      step();
      total++; if (o_debug_data !== 32'h0) begin bad++; $display("FAIL clear_word%0d got=%h exp=0", i, o_debug_data); end
    end
    i_debug_read = 1'b0;
    cpu(0, 1, 8'h00, 2'b10, 0, 32'h0);
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL sw_dropped got=%h exp=0", o_read_data); end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 64; i++) cpu(1, 0, 8'(i * 4), 2'b10, 0, 32'h5A000000 | i);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      i_debug_read = (k == 5); i_debug_address = 6'd40;
      step();
    end
    i_debug_read = 1'b0;
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL midclear_busy got=%b exp=1", o_busy); end
    total++; if (o_debug_data !== 32'h5A000028) begin bad++; $display("FAIL midclear_dbg got=%h exp=5a000028", o_debug_data); end
    i_reset_n = 1'b0;
    #2;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    total++; if (o_debug_data !== 32'h0) begin bad++; $display("FAIL rst_dbg got=%h exp=0", o_debug_data); end
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h exp=0", o_read_data); end
    total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b exp=0", o_misaligned); end
    step();
    i_reset_n = 1'b1;
    step(); step();
    for (int i = 0; i < 64; i++) begin
      logic [31:0] exp;
      exp = (i < 10) ? 32'h0 : (32'h5A000000 | i);
      i_debug_read = 1'b1; i_debug_address = 6'(i);
      step();
      total++; if (o_debug_data !== exp) begin bad++; $display("FAIL partial_word%0d got=%h exp=%h", i, o_debug_data, exp); end
    end
    i_debug_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_read_first();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
